// File: rtl/knn_vote.sv
// Majority-vote classifier that sits behind the KNN sorter. It reads the k nearest
// entries with a strobe, tallies labels, then scans the classes for a deterministic winner.
module knn_vote #(
    parameter int dataWidth   = 32,
    parameter int maxK        = 16,
    parameter int labelWidth  = 3,
    parameter int readLatency = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [31:0]                  k,
    input  logic [31:0]                  dataNameIn,
    input  logic [dataWidth-1:0]         dataValueIn,
    output logic                         rd_clk,
    output logic                         busy,
    output logic                         valid,
    output logic [labelWidth-1:0]        classOut,
    output logic [$clog2(maxK+1)-1:0]    voteCount,
    output logic [dataWidth-1:0]         winDist
);

    localparam int numClasses = 2 ** labelWidth;
    localparam int CW         = $clog2(maxK + 1);
    localparam int WW         = (readLatency > 1) ? $clog2(readLatency) : 1;

    typedef enum logic [2:0] {
        IDLE, CLEAR, STROBE, WAIT, TALLY, DECIDE, FINISH, DONE
    } state_t;

    state_t                          state;
    logic [CW-1:0]                   k_eff;
    logic [CW-1:0]                   idx;
    logic [WW-1:0]                   wait_cnt;
    logic [labelWidth-1:0]           scan_idx;
    logic [labelWidth-1:0]           best_class;
    logic [CW-1:0]                   best_count;
    logic [dataWidth-1:0]            best_dist;

    logic [numClasses-1:0][CW-1:0]        count_all;
    logic [numClasses-1:0][dataWidth-1:0] first_all;
    logic [labelWidth-1:0]           label;
    logic [CW-1:0]                   cur_count;
    logic [dataWidth-1:0]            cur_dist;
    logic                            cur_wins;
    logic                            unused_name;

    assign label       = dataNameIn[labelWidth-1:0];
    assign unused_name = ^dataNameIn[31:labelWidth];

    // One tally slot per class: cleared at the start of a vote, bumped when its label is read.
    for (genvar gi = 0; gi < numClasses; gi++) begin : g_class
        logic [CW-1:0]        count_reg;
        logic [dataWidth-1:0] first_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                count_reg <= '0;
                first_reg <= '0;
            end else if (state == CLEAR) begin
                count_reg <= '0;
                first_reg <= '1;
            end else if (state == TALLY && label == labelWidth'(gi)) begin
                count_reg <= count_reg + CW'(1);
                if (count_reg == '0)
                    first_reg <= dataValueIn;
            end
        end

        assign count_all[gi] = count_reg;
        assign first_all[gi] = first_reg;
    end

    assign cur_count = count_all[scan_idx];
    assign cur_dist  = first_all[scan_idx];
    // Ties on count go to the nearer first neighbour; a full tie keeps the lower class.
    assign cur_wins  = (cur_count > best_count) ||
                       ((cur_count == best_count) && (cur_count != '0) && (cur_dist < best_dist));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            k_eff      <= '0;
            idx        <= '0;
            wait_cnt   <= '0;
            scan_idx   <= '0;
            best_class <= '0;
            best_count <= '0;
            best_dist  <= '0;
            rd_clk     <= 1'b0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            classOut   <= '0;
            voteCount  <= '0;
            winDist    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        k_eff <= (k > 32'(maxK)) ? CW'(maxK) : CW'(k);
                        valid <= 1'b0;
                        busy  <= 1'b1;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    idx        <= '0;
                    scan_idx   <= '0;
                    best_class <= '0;
                    best_count <= '0;
                    best_dist  <= '1;
                    if (k_eff == '0) begin
                        state <= FINISH;
                    end else begin
                        state  <= STROBE;
                        rd_clk <= 1'b1;
                    end
                end
                STROBE: begin
                    rd_clk   <= 1'b0;
                    wait_cnt <= '0;
                    state    <= (readLatency > 1) ? WAIT : TALLY;
                end
                WAIT: begin
                    if (wait_cnt == WW'(readLatency - 2))
                        state <= TALLY;
                    else
                        wait_cnt <= wait_cnt + WW'(1);
                end
                TALLY: begin
                    idx <= idx + CW'(1);
                    if ((idx + CW'(1)) < k_eff) begin
                        state  <= STROBE;
                        rd_clk <= 1'b1;
                    end else begin
                        state <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (cur_wins) begin
                        best_class <= scan_idx;
                        best_count <= cur_count;
                        best_dist  <= cur_dist;
                    end
                    if (scan_idx == '1)
                        state <= FINISH;
                    else
                        scan_idx <= scan_idx + labelWidth'(1);
                end
                FINISH: begin
                    classOut  <= best_class;
                    voteCount <= best_count;
                    winDist   <= (best_count == '0) ? '0 : best_dist;
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// Bench for knn_vote: a latency-accurate sorter model, a directed table, a few
// hand-written sequences and randomized votes checked against an arithmetic model.
module tb_knn_vote;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] k = '0;
    logic [31:0] dataNameIn = '0;
    logic [31:0] dataValueIn = '0;
    logic        rd_clk;
    logic        busy;
    logic        valid;
    logic [2:0]  classOut;
    logic [4:0]  voteCount;
    logic [31:0] winDist;

    knn_vote dut (
        .clk(clk), .reset(reset), .start(start), .k(k),
        .dataNameIn(dataNameIn), .dataValueIn(dataValueIn),
        .rd_clk(rd_clk), .busy(busy), .valid(valid),
        .classOut(classOut), .voteCount(voteCount), .winDist(winDist)
    );

    always #5 clk = ~clk;

    int          cur_labels [64];
    logic [31:0] cur_dists  [64];
    logic        sorter_clear = 1'b0;
    logic        d1 = 1'b0;
    int          ptr = 0;
    int          cyc = 0;
    int          strobe_cnt = 0;
    int          last_strobe = -1;
    int          spacing_err = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    // Sorter: data for a strobe is valid only during the cycle RL cycles after the strobe.
    always @(posedge clk) begin
        d1 <= rd_clk;
        if (sorter_clear) ptr <= 0;
        if (d1) begin
            dataNameIn  <= ($urandom & ~32'h7) | 32'(cur_labels[ptr & 63]);
            dataValueIn <= cur_dists[ptr & 63];
            ptr <= ptr + 1;
        end else begin
            dataNameIn  <= $urandom;
            dataValueIn <= $urandom;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sorter_clear) begin
            strobe_cnt  <= 0;
            last_strobe <= -1;
            spacing_err <= 0;
        end else if (rd_clk) begin
            strobe_cnt <= strobe_cnt + 1;
            if (last_strobe >= 0 && (cyc - last_strobe) != RL + 1)
                spacing_err <= spacing_err + 1;
            last_strobe <= cyc;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    // Reference: winner has the most votes; among those, the smallest first-seen
    // distance; among those, the lowest class number. No votes gives all zeros.
    function automatic void model(input int kk, output int ec, output int en,
                                  output logic [31:0] ed);
        int          cnt [8];
        logic [31:0] fd  [8];
        int          keff;
        int          maxc;
        logic [31:0] bd;
        keff = (kk > 16) ? 16 : kk;
        for (int c = 0; c < 8; c++) begin cnt[c] = 0; fd[c] = '0; end
        for (int i = 0; i < keff; i++) begin
            if (cnt[cur_labels[i] & 7] == 0) fd[cur_labels[i] & 7] = cur_dists[i];
            cnt[cur_labels[i] & 7]++;
        end
        maxc = 0;
        for (int c = 0; c < 8; c++) if (cnt[c] > maxc) maxc = cnt[c];
        ec = 0; en = maxc; ed = '0;
        if (maxc > 0) begin
            bd = '1;
            for (int c = 0; c < 8; c++)
                if (cnt[c] == maxc && fd[c] < bd) begin bd = fd[c]; ec = c; end
            ed = bd;
        end
    endfunction

    task automatic run_vote(input string tag, input int kk, input int e_class,
                            input int e_count, input logic [31:0] e_dist,
                            input int e_lat, input bit hold);
        int n;
        int e_str;
        e_str = (kk > 16) ? 16 : kk;
        @(negedge clk);
        start = 1'b1; k = 32'(kk); sorter_clear = 1'b1;
        @(negedge clk);
        sorter_clear = 1'b0;
        if (!hold) start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_valid_drop"}, valid, 0);
        n = 0;
        while (!valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        $display("vote %s k=%0d class=%0d count=%0d dist=%0d latency=%0d strobes=%0d",
                 tag, kk, classOut, voteCount, winDist, n, strobe_cnt);
        check({tag, "_latency"}, n, e_lat);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_class"}, classOut, e_class);
        check({tag, "_count"}, voteCount, e_count);
        check({tag, "_dist"}, winDist, e_dist);
        check({tag, "_strobes"}, strobe_cnt, e_str);
        check({tag, "_spacing"}, spacing_err, 0);
        repeat (2) @(negedge clk);
        check({tag, "_held_valid"}, valid, 1);
        check({tag, "_held_class"}, classOut, e_class);
        check({tag, "_held_dist"}, winDist, e_dist);
    endtask

    typedef struct packed {
        int           kk;
        logic [63:0]  lab;   // nibble i = label of entry i
        logic [127:0] dst;   // byte i = distance of entry i
        int           e_class;
        int           e_count;
        int           e_dist;
        int           e_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int ec, en, kk, base, lat;
        logic [31:0] ed;

        vecs[0] = '{5,  64'h12122,            128'h0a09060503,                        2, 3,  3, 25};
        vecs[1] = '{4,  64'h1331,             128'h09080704,                          1, 2,  4, 22};
        vecs[2] = '{4,  64'h3113,             128'h09080704,                          3, 2,  4, 22};
        vecs[3] = '{0,  64'h0,                128'h0,                                 0, 0,  0, 2};
        vecs[4] = '{40, 64'h7777777777777777, 128'h100f0e0d0c0b0a090807060504030201, 7, 16, 1, 58};
        vecs[5] = '{2,  64'h25,               128'h0606,                              2, 1,  6, 16};
        vecs[6] = '{1,  64'h4,                128'h00,                                4, 1,  0, 13};

        repeat (3) @(negedge clk);
        check("rst_rd_clk", rd_clk, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_class", classOut, 0);
        check("rst_count", voteCount, 0);
        check("rst_dist", winDist, 0);
        reset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 16; i++) begin
                cur_labels[i] = int'(vecs[v].lab[4*i +: 4]);
                cur_dists[i]  = 32'(vecs[v].dst[8*i +: 8]);
            end
            run_vote($sformatf("vec%0d", v), vecs[v].kk, vecs[v].e_class,
                     vecs[v].e_count, 32'(vecs[v].e_dist), vecs[v].e_lat, 1'b0);
        end

        // start held high for the whole vote, then a clean restart.
        cur_labels[0] = 1; cur_labels[1] = 0; cur_labels[2] = 1;
        cur_dists[0] = 2;  cur_dists[1] = 3;  cur_dists[2] = 4;
        run_vote("hold", 3, 1, 2, 32'd2, 19, 1'b1);
        cur_labels[0] = 6; cur_labels[1] = 6;
        cur_dists[0] = 1;  cur_dists[1] = 2;
        run_vote("restart", 2, 6, 2, 32'd1, 16, 1'b0);

        // Reset during a k=6 vote after two strobes.
        for (int i = 0; i < 6; i++) begin cur_labels[i] = 6; cur_dists[i] = 32'(i); end
        @(negedge clk);
        start = 1'b1; k = 32'd6; sorter_clear = 1'b1;
        @(negedge clk);
        start = 1'b0; sorter_clear = 1'b0;
        begin
            int n;
            n = 0;
            while (strobe_cnt < 2 && n < 100) begin @(negedge clk); n++; end
            check("midrst_reach_2_strobes", strobe_cnt, 2);
        end
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_rd_clk", rd_clk, 0);
        check("midrst_valid", valid, 0);
        repeat (8) @(negedge clk);
        check("midrst_no_strobes", strobe_cnt, 2);
        check("midrst_class", classOut, 0);
        reset = 1'b1;
        cur_labels[0] = 6; cur_labels[1] = 1; cur_labels[2] = 1;
        cur_dists[0] = 1;  cur_dists[1] = 2;  cur_dists[2] = 3;
        run_vote("postrst", 3, 1, 2, 32'd2, 19, 1'b0);

        // Randomized votes against the reference model.
        for (int t = 0; t < 25; t++) begin
            kk = $urandom_range(0, 20);
            base = int'($urandom & 32'hffff_0000);
            for (int i = 0; i < 20; i++) begin
                cur_labels[i] = (t % 2 == 1) ? $urandom_range(0, 2) : $urandom_range(0, 7);
                base += $urandom_range(0, 3);
                cur_dists[i] = 32'(base);
            end
            model(kk, ec, en, ed);
            lat = (kk == 0) ? 2 : ((kk > 16) ? 16 : kk) * (RL + 1) + 10;
            run_vote($sformatf("rand%0d", t), kk, ec, en, ed, lat, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/knn_vote.md
Name: knn_vote

Overview:
- Downstream stage of the KNN accelerator top.
- Once the host signals that the sorter holds the final neighbour list, this block pulls the k nearest entries out of the sorter one at a time, using the sorter's read strobe.
- It tallies class labels and produces a majority-vote classification, with deterministic tie-breaking.
- The result is presented to the register interface as a held, valid-qualified word.

Parameters:
- dataWidth, 32, width of distance values returned by the sorter
- maxK, 16, largest supported k; larger requests are clamped
- labelWidth, 3, class label width; numClasses = 2**labelWidth
- readLatency, 2, cycles from strobe-high edge to valid sorter output

Ports:
- clk  input  1  single system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse: begin a vote
- k  input  32  number of neighbours to read; sampled on accepted start
- dataNameIn  input  32  sorter name output; label = dataNameIn[labelWidth-1:0], upper bits ignored
- dataValueIn  input  dataWidth  sorter distance output (nearest first)
- rd_clk  output  1  read strobe to sorter; one-cycle high pulse per entry
- busy  output  1  high from accepted start until valid asserts
- valid  output  1  result valid; held until next accepted start
- classOut  output  labelWidth  winning class
- voteCount  output  $clog2(maxK+1)  votes for winning class
- winDist  output  dataWidth  nearest distance within winning class

Behaviour:
- Reset (reset low, async): all outputs 0, FSM in IDLE, tallies cleared.
- Start acceptance:
  - start is accepted only in IDLE or DONE; it is ignored while busy.
  - On acceptance: kEff = min(k, maxK); valid drops; busy rises the next cycle.
- FSM states:
  - IDLE / DONE: wait for start.
  - CLEAR (1 cycle): zero all per-class counts; set every firstDist to all-ones; idx = 0.
    - If kEff = 0, go to DONE with classOut = 0, voteCount = 0, winDist = 0, valid = 1.
  - STROBE (1 cycle): rd_clk = 1.
  - WAIT: readLatency-1 cycles with rd_clk = 0.
  - TALLY (1 cycle): sample dataNameIn/dataValueIn; count[label]++.
    - If count[label] was 0, firstDist[label] = dataValueIn.
    - idx++; go to STROBE if idx < kEff, else DECIDE.
  - DECIDE: numClasses cycles, scanning class 0 upward. Class c replaces the current best if either:
    - count[c] > bestCount, or
    - count[c] = bestCount, count[c] > 0 and firstDist[c] < bestDist.
    - Equal count and equal distance keep the lower index.
  - Scan end: load classOut, voteCount, winDist; valid = 1; busy = 0; go to DONE.
- Timing:
  - Strobes are spaced readLatency+1 cycles apart; rd_clk is never high for two consecutive cycles.
  - Latency from accepted start to valid = 1 + kEff*(readLatency+1) + numClasses + 1 cycles.
- Arithmetic:
  - Counts saturate-free by construction, since count width is $clog2(maxK+1) and sum ≤ kEff.
  - Distance comparisons are unsigned.
- Boundary conditions:
  - Reset asserted mid-vote: immediate return to reset values; no further strobes.
  - start coincident with the valid-asserting cycle: ignored, because the FSM is not yet in DONE.
  - Outputs are stable and unchanged while in DONE.

Test Plan:
- k=5, labels 2,2,1,2,1 with distances 3,5,6,9,10 -> exactly 5 rd_clk pulses, each 1 cycle, spaced 3 cycles; valid after 1+15+8+1=25 cycles; classOut=2, voteCount=3, winDist=3.
- k=4, labels 1,3,3,1 with distances 4,7,8,9 (tie 2-2) -> classOut=1, winDist=4; repeat with first distances swapped (labels 3,1,1,3) -> classOut=3.
- k=0 -> no rd_clk pulses; valid 2 cycles after start; classOut=0, voteCount=0, winDist=0.
- k=40 (maxK=16), all labels 7 -> exactly 16 strobes; voteCount=16, classOut=7.
- start pulsed every cycle during a k=3 vote -> single vote, 3 strobes, result unaffected; a start after valid clears valid and restarts.
- reset pulled low after 2 strobes of a k=6 vote -> outputs 0 immediately, rd_clk stays low; a fresh start after release gives a correct result with no stale counts.
